i2c_slave_bit_byte_cnt: RTL and testbench

Parametrised bit/byte sequencer for the I2C slave datapath. It counts SCL bit ticks within a byte and identifies the data-bit and ACK phases. It counts completed bytes per transfer and flags the last expected byte. It sits between the SCL/SDA edge detector (start/stop/bit_tick) and the slave control FSM and shift register.

---
 rtl/i2c_slave_bit_byte_cnt_pkg.sv | 23 ++
 rtl/i2c_slave_bit_byte_cnt_counter.sv | 36 +++
 rtl/i2c_slave_bit_byte_cnt.sv | 142 ++++++++++++++
 tb/tb_i2c_slave_bit_byte_cnt.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_bit_byte_cnt_pkg.sv
// ----------------------------------------------------------------------------
// i2c_slave_pkg
// Shared types and constants for the I2C slave bit/byte sequencer.
//   BIT_CNT_W        : width of the per-byte bit counter (covers DATA_BITS 1..15)
//   i2c_cnt_state_e  : sequencer state (IDLE, DATA, ACK)
//   bit_cnt_last()   : bit_cnt value at which the final data bit is counted
// ----------------------------------------------------------------------------
package i2c_slave_pkg;

    localparam int BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } i2c_cnt_state_e;

    // Counter value seen on the tick that completes a byte of data_bits bits.
    function automatic logic [BIT_CNT_W-1:0] bit_cnt_last(input int data_bits);
        return BIT_CNT_W'(data_bits - 1);
    endfunction

endpackage

// File: rtl/i2c_slave_bit_byte_cnt_counter.sv
// ----------------------------------------------------------------------------
// i2c_slave_bit_byte_cnt_counter
// Generic up-counter with synchronous clear (clear has priority over inc).
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear to zero
//   inc_i   : increment by one (wraps at 2**COUNTER_WIDTH)
//   cnt_o   : registered count
// ----------------------------------------------------------------------------
module i2c_slave_bit_byte_cnt_counter #(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     inc_i,
    output logic [COUNTER_WIDTH-1:0] cnt_o
);

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/i2c_slave_bit_byte_cnt.sv
// ----------------------------------------------------------------------------
// i2c_slave_bit_byte_cnt
// Bit/byte sequencer for the I2C slave datapath. Counts SCL bit ticks within a
// byte, marks the ACK slot, counts completed bytes per frame and flags the
// last expected byte.
// Optional feature macro: I2C_SLAVE_BYTE_OVF_EN (sticky byte overflow flag).
// Ports:
//   pclk, presetn : clock, asynchronous active-low reset
//   bit_tick      : one pulse per SCL rising edge
//   frame_start   : START / repeated START pulse
//   frame_stop    : STOP pulse
//   cnt_en        : qualifies bit_tick (start/stop act regardless)
//   ovf_clr       : clears the sticky overflow flag
//   bit_cnt       : data bits counted in the current byte
//   byte_cnt      : completed bytes in the current frame
//   byte_done     : one-cycle pulse when the last data bit is counted
//   in_ack        : high during the ACK slot
//   last_byte     : byte_cnt == MAX_BYTES-1
//   busy          : sequencer not idle
//   ovf           : sticky overflow (0 without the optional feature)
// ----------------------------------------------------------------------------
module i2c_slave_bit_byte_cnt
    import i2c_slave_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BYTE_CNT_W = 8,
    parameter int MAX_BYTES  = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  bit_tick,
    input  logic                  frame_start,
    input  logic                  frame_stop,
    input  logic                  cnt_en,
    input  logic                  ovf_clr,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic                  byte_done,
    output logic                  in_ack,
    output logic                  last_byte,
    output logic                  busy,
    output logic                  ovf
);

    if (DATA_BITS < 1 || DATA_BITS > 15) begin : g_bad_data_bits
        $error("DATA_BITS must be within 1..15");
    end
    if (MAX_BYTES < 1 || (BYTE_CNT_W < 31 && MAX_BYTES > (1 << BYTE_CNT_W))) begin : g_bad_max_bytes
        $error("MAX_BYTES must be within 1..2**BYTE_CNT_W");
    end

    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = bit_cnt_last(DATA_BITS);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(MAX_BYTES - 1);

    i2c_cnt_state_e          state_q;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q;
    logic                    byte_done_q;
    logic                    in_ack_q;
    logic                    busy_q;
    logic [BIT_CNT_W-1:0]    bit_cnt_w;

    // A tick only counts when enabled and no frame event claims the cycle.
    logic tick_ok, data_tick, ack_tick, bit_clr;
    assign tick_ok   = bit_tick & cnt_en & ~frame_start & ~frame_stop;
    assign data_tick = tick_ok & (state_q == DATA);
    assign ack_tick  = tick_ok & (state_q == ACK);
    // Leaving ACK restarts the bit count for the next byte.
    assign bit_clr   = frame_start | frame_stop | ack_tick;

    // Increments only in DATA, so the count holds at DATA_BITS through ACK.
    i2c_slave_bit_byte_cnt_counter #(
        .COUNTER_WIDTH (BIT_CNT_W)
    ) u_bit_cnt (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .clr_i  (bit_clr),
        .inc_i  (data_tick),
        .cnt_o  (bit_cnt_w)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            byte_done_q <= 1'b0;
            in_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            if (frame_stop) begin
                state_q    <= IDLE;
                byte_cnt_q <= '0;
                in_ack_q   <= 1'b0;
                busy_q     <= 1'b0;
            end else if (frame_start) begin
                state_q    <= DATA;
                byte_cnt_q <= '0;
                in_ack_q   <= 1'b0;
                busy_q     <= 1'b1;
            end else if (tick_ok) begin
                case (state_q)
                    DATA: begin
                        if (bit_cnt_w == LAST_BIT) begin
                            state_q     <= ACK;
                            in_ack_q    <= 1'b1;
                            byte_done_q <= 1'b1;
                        end
                    end
                    ACK: begin
                        state_q    <= DATA;
                        in_ack_q   <= 1'b0;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bit_cnt   = bit_cnt_w;
    assign byte_cnt  = byte_cnt_q;
    assign byte_done = byte_done_q;
    assign in_ack    = in_ack_q;
    assign busy      = busy_q;
    assign last_byte = (byte_cnt_q == LAST_BYTE);

`ifdef I2C_SLAVE_BYTE_OVF_EN
    // Set when byte MAX_BYTES+1 begins; set beats a same-cycle clear.
    logic ovf_q;
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                   ovf_q <= 1'b0;
        else if (ack_tick && last_byte) ovf_q <= 1'b1;
        else if (ovf_clr)               ovf_q <= 1'b0;
    end
    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_bit_byte_cnt.sv
module tb_i2c_slave_bit_byte_cnt;

    logic pclk = 1'b0;
    logic presetn, bit_tick, frame_start, frame_stop, cnt_en, ovf_clr;

    logic [3:0] bit_cnt8, bit_cnt7;
    logic [7:0] byte_cnt8, byte_cnt7;
    logic byte_done8, in_ack8, last_byte8, busy8, ovf8;
    logic byte_done7, in_ack7, last_byte7, busy7, ovf7;

    always #5 pclk = ~pclk;

    i2c_slave_bit_byte_cnt u_dut8 (
        .pclk(pclk), .presetn(presetn), .bit_tick(bit_tick), .frame_start(frame_start),
        .frame_stop(frame_stop), .cnt_en(cnt_en), .ovf_clr(ovf_clr),
        .bit_cnt(bit_cnt8), .byte_cnt(byte_cnt8), .byte_done(byte_done8), .in_ack(in_ack8),
        .last_byte(last_byte8), .busy(busy8), .ovf(ovf8)
    );

    i2c_slave_bit_byte_cnt #(.DATA_BITS(7), .BYTE_CNT_W(8), .MAX_BYTES(3)) u_dut7 (
        .pclk(pclk), .presetn(presetn), .bit_tick(bit_tick), .frame_start(frame_start),
        .frame_stop(frame_stop), .cnt_en(cnt_en), .ovf_clr(ovf_clr),
        .bit_cnt(bit_cnt7), .byte_cnt(byte_cnt7), .byte_done(byte_done7), .in_ack(in_ack7),
        .last_byte(last_byte7), .busy(busy7), .ovf(ovf7)
    );

    // Reference model: st 0=idle, 1=data, 2=ack
    typedef struct {
        int st; int bitc; int bytec;
        bit ack; bit done; bit ovf;
    } mdl_t;
    typedef struct { mdl_t a; mdl_t b; } pair_t;

    pair_t sb[$];
    mdl_t  m8, m7;
    int    n_asrt = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic mdl_t step(input mdl_t m, input int db, input int maxb, input int bw,
                                  input bit stp, input bit sta, input bit tk, input bit en,
                                  input bit clr);
        mdl_t n = m;
        n.done = 1'b0;
`ifdef I2C_SLAVE_BYTE_OVF_EN
        if (clr) n.ovf = 1'b0;
`endif
        if (stp) begin
            n.st = 0; n.bitc = 0; n.bytec = 0; n.ack = 1'b0;
        end else if (sta) begin
            n.st = 1; n.bitc = 0; n.bytec = 0; n.ack = 1'b0;
        end else if (tk && en) begin
            if (m.st == 1) begin
                n.bitc = m.bitc + 1;
                if (n.bitc == db) begin n.st = 2; n.ack = 1'b1; n.done = 1'b1; end
            end else if (m.st == 2) begin
                n.st = 1; n.bitc = 0; n.ack = 1'b0;
                n.bytec = (m.bytec + 1) % (1 << bw);
`ifdef I2C_SLAVE_BYTE_OVF_EN
                if (m.bytec == maxb - 1) n.ovf = 1'b1;
`endif
            end
        end
        return n;
    endfunction

    task automatic chk_mdl(input string p, input mdl_t m, input int maxb,
                           input logic [3:0] bc, input logic [7:0] yc, input logic bd,
                           input logic ia, input logic lb, input logic bz, input logic ov);
        chk({p, ".bit_cnt"},   32'(bc), 32'(m.bitc));
        chk({p, ".byte_cnt"},  32'(yc), 32'(m.bytec));
        chk({p, ".byte_done"}, 32'(bd), 32'(m.done));
        chk({p, ".in_ack"},    32'(ia), 32'(m.ack));
        chk({p, ".last_byte"}, 32'(lb), 32'(m.bytec == maxb - 1));
        chk({p, ".busy"},      32'(bz), 32'(m.st != 0));
        chk({p, ".ovf"},       32'(ov), 32'(m.ovf));
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic cyc(input bit stp, input bit sta, input bit tk, input bit en, input bit clr);
        pair_t p;
        frame_stop = stp; frame_start = sta; bit_tick = tk; cnt_en = en; ovf_clr = clr;
        m8 = step(m8, 8, 16, 8, stp, sta, tk, en, clr);
        m7 = step(m7, 7, 3, 8, stp, sta, tk, en, clr);
        sb.push_back('{m8, m7});
        @(posedge pclk);
        @(negedge pclk);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            p = sb.pop_front();
            chk_mdl("d8", p.a, 16, bit_cnt8, byte_cnt8, byte_done8, in_ack8, last_byte8, busy8, ovf8);
            chk_mdl("d7", p.b, 3, bit_cnt7, byte_cnt7, byte_done7, in_ack7, last_byte7, busy7, ovf7);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 1, 0);
    endtask

    task automatic chk_zero(input string p);
        chk({p, ".bit_cnt8"},  32'(bit_cnt8), 0);
        chk({p, ".byte_cnt8"}, 32'(byte_cnt8), 0);
        chk({p, ".in_ack8"},   32'(in_ack8), 0);
        chk({p, ".busy8"},     32'(busy8), 0);
        chk({p, ".done8"},     32'(byte_done8), 0);
        chk({p, ".ovf8"},      32'(ovf8), 0);
        chk({p, ".bit_cnt7"},  32'(bit_cnt7), 0);
        chk({p, ".busy7"},     32'(busy7), 0);
        chk({p, ".ovf7"},      32'(ovf7), 0);
    endtask

    task automatic model_reset();
        m8 = '{default: 0};
        m7 = '{default: 0};
    endtask

    initial begin
        presetn = 1'b0; bit_tick = 1'b0; frame_start = 1'b0; frame_stop = 1'b0;
        cnt_en = 1'b1; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge pclk);
        chk_zero("rst");
        presetn = 1'b1;
        @(negedge pclk);

        // idle ticks are ignored
        ticks(2);

        // default byte: 8 data ticks then the ACK tick
        cyc(0, 1, 0, 1, 0);
        ticks(8);
        chk("dflt.done",  32'(byte_done8), 1);
        chk("dflt.ack",   32'(in_ack8), 1);
        chk("dflt.bit",   32'(bit_cnt8), 8);
        ticks(1);
        chk("dflt.done0", 32'(byte_done8), 0);
        chk("dflt.ack0",  32'(in_ack8), 0);
        chk("dflt.bit0",  32'(bit_cnt8), 0);
        chk("dflt.byte",  32'(byte_cnt8), 1);

        // 7-bit bytes, 3 per frame: last byte then overflow
        cyc(0, 1, 0, 1, 0);
        ticks(16);
        chk("b7.byte2", 32'(byte_cnt7), 2);
        chk("b7.last",  32'(last_byte7), 1);
        ticks(8);
        chk("b7.byte3", 32'(byte_cnt7), 3);
`ifdef I2C_SLAVE_BYTE_OVF_EN
        chk("b7.ovf", 32'(ovf7), 1);
`else
        chk("b7.ovf", 32'(ovf7), 0);
`endif
        cyc(0, 0, 0, 1, 1);
        chk("b7.ovfclr", 32'(ovf7), 0);

        // repeated START with a same-cycle tick at bit_cnt=4
        cyc(0, 1, 0, 1, 0);
        ticks(4);
        chk("rs.bit4", 32'(bit_cnt8), 4);
        cyc(0, 1, 1, 1, 0);
        chk("rs.bit",  32'(bit_cnt8), 0);
        chk("rs.byte", 32'(byte_cnt8), 0);
        chk("rs.busy", 32'(busy8), 1);

        // STOP + START together during ACK
        ticks(8);
        chk("ss.inack", 32'(in_ack8), 1);
        cyc(1, 1, 0, 1, 0);
        chk("ss.busy", 32'(busy8), 0);
        ticks(3);
        chk("ss.bit",  32'(bit_cnt8), 0);

        // cnt_en low freezes the count
        cyc(0, 1, 0, 1, 0);
        ticks(2);
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("en.hold", 32'(bit_cnt8), 2);
        ticks(6);
        chk("en.done", 32'(byte_done8), 1);

        // random traffic
        cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 60) == 0, ($urandom % 45) == 0, ($urandom % 4) != 0,
                ($urandom % 6) != 0, ($urandom % 8) == 0);

        // asynchronous reset mid-frame at bit_cnt=5
        cyc(0, 1, 0, 1, 0);
        ticks(5);
        chk("mr.bit5", 32'(bit_cnt8), 5);
        #2 presetn = 1'b0;
        #1 chk_zero("mr");
        model_reset();
        @(negedge pclk);
        presetn = 1'b1;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
